exp5_condicionador_entradas: RTL and testbench

Input-conditioning stage placed directly upstream of the experiment datapath/control pair. Synchronizes and debounces the four `chaves` switches and the `iniciar` button, then turns a debounced key press into a single-cycle `jogada` pulse with a registered key value. The control unit consumes `iniciar_pulso` and `jogada`; the datapath compares against `jogada_valor`; `db_estado` feeds a `hexa7seg` display.

---
 rtl/exp5_condicionador_entradas_pkg.sv | 9 +
 rtl/exp5_condicionador_entradas_debounce.sv | 36 +++
 rtl/exp5_condicionador_entradas.sv | 66 ++++++
 tb/tb_exp5_condicionador_entradas.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/exp5_condicionador_entradas_pkg.sv
// exp5_condicionador_entradas_pkg: press FSM state codes and default debounce length
package exp5_condicionador_entradas_pkg;
    typedef enum logic [3:0] {
        OCIOSO  = 4'h0,
        JOGADA  = 4'h1,
        AGUARDA = 4'h2
    } estado_t;
    localparam int DEBOUNCE_PADRAO = 4;
endpackage

// File: rtl/exp5_condicionador_entradas_debounce.sv
// exp5_condicionador_entradas_debounce: two-flop synchronizer plus saturating stability counter
module exp5_condicionador_entradas_debounce #(
    parameter int LARGURA         = 1,
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [LARGURA-1:0] i_entrada,
    output logic [LARGURA-1:0] o_estavel
);
    localparam int CW = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0] MAX = CW'(DEBOUNCE_CICLOS - 1);
    logic [LARGURA-1:0] r_s1, r_s2, r_candidato, r_estavel;
    logic [CW-1:0]      r_contador;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_candidato <= '0;
            r_contador  <= '0;
            r_estavel   <= '0;
        end else begin
            r_s1 <= i_entrada;
            r_s2 <= r_s1;
            if (r_s2 != r_candidato) begin
                r_candidato <= r_s2;
                r_contador  <= '0;
            end else if (r_contador == MAX) begin
                r_estavel <= r_candidato;
            end else begin
                r_contador <= r_contador + 1'b1;
            end
        end
    end
    assign o_estavel = r_estavel;
endmodule

// File: rtl/exp5_condicionador_entradas.sv
// exp5_condicionador_entradas: debounced switches/start button, one-shot press pulse with captured key
module exp5_condicionador_entradas
    import exp5_condicionador_entradas_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_chaves,
    input  logic       i_iniciar,
    input  logic       i_habilita,
    output logic [3:0] o_chaves_limpas,
    output logic       o_jogada,
    output logic [3:0] o_jogada_valor,
    output logic       o_jogada_valida,
    output logic       o_iniciar_pulso,
    output logic [3:0] o_db_estado
);
    estado_t    r_estado, w_proximo;
    logic [3:0] w_chaves, r_valor;
    logic       w_iniciar, r_iniciar_ant, r_iniciar_pulso;
    exp5_condicionador_entradas_debounce #(.LARGURA(4), .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_db_chaves (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_entrada (i_chaves),
        .o_estavel (w_chaves)
    );
    exp5_condicionador_entradas_debounce #(.LARGURA(1), .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_db_iniciar (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_entrada (i_iniciar),
        .o_estavel (w_iniciar)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_estado        <= OCIOSO;
            r_valor         <= '0;
            r_iniciar_ant   <= 1'b0;
            r_iniciar_pulso <= 1'b0;
        end else begin
            r_estado        <= w_proximo;
            r_iniciar_ant   <= w_iniciar;
            r_iniciar_pulso <= w_iniciar & ~r_iniciar_ant;
            if (w_proximo == JOGADA)
                r_valor <= w_chaves;
        end
    end
    // A press seen while disabled is parked in AGUARDA so it cannot fire later
    always_comb begin
        w_proximo = OCIOSO;
        case (r_estado)
            OCIOSO:  w_proximo = (w_chaves != 4'd0) ? (i_habilita ? JOGADA : AGUARDA) : OCIOSO;
            JOGADA:  w_proximo = AGUARDA;
            AGUARDA: w_proximo = (w_chaves == 4'd0) ? OCIOSO : AGUARDA;
            default: w_proximo = OCIOSO;
        endcase
    end
    always_comb begin
        o_jogada        = (r_estado == JOGADA);
        o_db_estado     = r_estado;
        o_jogada_valida = ($countones(r_valor) == 1);
    end
    assign o_chaves_limpas = w_chaves;
    assign o_jogada_valor  = r_valor;
    assign o_iniciar_pulso = r_iniciar_pulso;
endmodule

// File: tb/tb_exp5_condicionador_entradas.sv
// tb_exp5_condicionador_entradas: directed scenarios with a scoreboard of expected pulses
module tb_exp5_condicionador_entradas;
    logic       clk = 0, rst_n = 1;
    logic [3:0] chaves = 0;
    logic       iniciar = 0, habilita = 1;
    logic [3:0] o_chaves_limpas, o_jogada_valor, o_db_estado;
    logic       o_jogada, o_jogada_valida, o_iniciar_pulso;
    typedef struct {int ciclo; logic [3:0] valor; logic valida;} jog_t;
    jog_t q_jog[$];
    int   q_ini[$];
    int   cyc = 0, n_total = 0, n_pass = 0;
    exp5_condicionador_entradas #(.DEBOUNCE_CICLOS(4)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_chaves        (chaves),
        .i_iniciar       (iniciar),
        .i_habilita      (habilita),
        .o_chaves_limpas (o_chaves_limpas),
        .o_jogada        (o_jogada),
        .o_jogada_valor  (o_jogada_valor),
        .o_jogada_valida (o_jogada_valida),
        .o_iniciar_pulso (o_iniciar_pulso),
        .o_db_estado     (o_db_estado)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] saidas();
        return {17'd0, o_chaves_limpas, o_jogada, o_jogada_valor, o_jogada_valida, o_iniciar_pulso, o_db_estado};
    endfunction
    // Pulses are popped from the scoreboard as the DUT emits them
    always @(negedge clk) begin
        if (o_jogada === 1'b1) begin
            if (q_jog.size() == 0) chk("jogada_espuria", {31'd0, o_jogada}, 32'd0);
            else begin : pop_jog
                jog_t e;
                e = q_jog.pop_front();
                chk("jogada_ciclo", cyc, e.ciclo);
                chk("jogada_valor", {28'd0, o_jogada_valor}, {28'd0, e.valor});
                chk("jogada_valida", {31'd0, o_jogada_valida}, {31'd0, e.valida});
            end
        end
        if (o_iniciar_pulso === 1'b1) begin
            if (q_ini.size() == 0) chk("iniciar_espurio", {31'd0, o_iniciar_pulso}, 32'd0);
            else chk("iniciar_ciclo", cyc, q_ini.pop_front());
        end
    end
    initial begin
        #2 rst_n = 0;
        #1 chk("reset_saidas", saidas(), 32'd0);
        tick(2);
        rst_n = 1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("ocioso", saidas(), 32'd0);
        end
        chaves = 4'b0100;
        q_jog.push_back('{cyc + 8, 4'b0100, 1'b1});
        tick(6);
        chk("limpas_antes", {28'd0, o_chaves_limpas}, 32'd0);
        tick(1);
        chk("limpas_0100", {28'd0, o_chaves_limpas}, 32'h4);
        tick(1);
        chk("estado_jogada", {28'd0, o_db_estado}, 32'h1);
        tick(1);
        chk("estado_aguarda", {28'd0, o_db_estado}, 32'h2);
        chaves = 4'b0000;
        tick(10);
        chk("soltar_limpas", {28'd0, o_chaves_limpas}, 32'd0);
        chk("soltar_estado", {28'd0, o_db_estado}, 32'd0);
        chk("valor_mantido", {28'd0, o_jogada_valor}, 32'h4);
        chaves = 4'b0001;
        tick(1);
        chaves = 4'b0000;
        tick(1);
        chaves = 4'b0001;
        q_jog.push_back('{cyc + 8, 4'b0001, 1'b1});
        tick(6);
        chk("ressalto_limpas", {28'd0, o_chaves_limpas}, 32'd0);
        tick(1);
        chk("ressalto_estavel", {28'd0, o_chaves_limpas}, 32'h1);
        tick(5);
        chaves = 4'b0000;
        tick(10);
        chaves = 4'b0001;
        q_jog.push_back('{cyc + 8, 4'b0001, 1'b1});
        tick(12);
        chaves = 4'b0011;
        tick(10);
        chk("troca_limpas", {28'd0, o_chaves_limpas}, 32'h3);
        chk("troca_estado", {28'd0, o_db_estado}, 32'h2);
        chk("troca_valor", {28'd0, o_jogada_valor}, 32'h1);
        chaves = 4'b0000;
        tick(10);
        chaves = 4'b0011;
        q_jog.push_back('{cyc + 8, 4'b0011, 1'b0});
        tick(10);
        chk("valida_dois_bits", {31'd0, o_jogada_valida}, 32'd0);
        chaves = 4'b0000;
        tick(10);
        habilita = 0;
        chaves = 4'b1000;
        tick(10);
        chk("desab_estado", {28'd0, o_db_estado}, 32'h2);
        habilita = 1;
        tick(10);
        chk("hab_meio_estado", {28'd0, o_db_estado}, 32'h2);
        chaves = 4'b0000;
        tick(10);
        chk("hab_soltar", {28'd0, o_db_estado}, 32'd0);
        chaves = 4'b1000;
        q_jog.push_back('{cyc + 8, 4'b1000, 1'b1});
        tick(10);
        chaves = 4'b0000;
        tick(10);
        iniciar = 1;
        q_ini.push_back(cyc + 8);
        tick(10);
        iniciar = 0;
        tick(10);
        chaves = 4'b0010;
        iniciar = 1;
        q_jog.push_back('{cyc + 8, 4'b0010, 1'b1});
        q_ini.push_back(cyc + 8);
        tick(10);
        chaves = 4'b0000;
        iniciar = 0;
        tick(10);
        chaves = 4'b0100;
        tick(7);
        chk("pre_reset_limpas", {28'd0, o_chaves_limpas}, 32'h4);
        rst_n = 0;
        #1 chk("reset_async", saidas(), 32'd0);
        tick(3);
        rst_n = 1;
        q_jog.push_back('{cyc + 8, 4'b0100, 1'b1});
        tick(12);
        chaves = 4'b0000;
        tick(10);
        chk("fila_jogada", q_jog.size(), 32'd0);
        chk("fila_iniciar", q_ini.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
